crc32_stream: RTL and testbench

CRC32_STREAM -- requirements
Module: crc32_stream

---
 rtl/crc32_pkg.sv | 25 ++
 rtl/crc32_stream_byte_fold.sv | 15 +
 rtl/crc32_stream.sv | 122 ++++++++++++
 tb/tb_crc32_stream.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc32_pkg.sv
// Shared CRC-32 (IEEE 802.3, reflected) constants, FSM state type and byte-fold function.
package crc32_pkg;

    localparam logic [31:0] CRC32_POLY_REFL      = 32'hEDB88320;
    localparam logic [31:0] CRC32_RESIDUE        = 32'hDEBB20E3;
    localparam logic [31:0] CRC32_INIT_DEFAULT   = '1;
    localparam logic [31:0] CRC32_XOROUT_DEFAULT = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } crc_state_t;

    // Folds one byte into the register, LSB of the byte first.
    function automatic logic [31:0] crc32_fold_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_stream_byte_fold.sv
// One byte lane of the CRC chain; a disabled lane passes the register through untouched.
module crc32_byte_fold
    import crc32_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    input  logic        enable,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = enable ? crc32_fold_byte(crc_in, data) : crc_in;
    end

endmodule

// File: rtl/crc32_stream.sv
// Streaming CRC-32 over DATA_W-bit beats with frame delimiting and a held result.
// Optional `CRC32_STREAM_CHECK_EN adds crc_ok/crc_err residue check outputs.
module crc32_stream
    import crc32_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter logic [31:0] CRC_INIT   = CRC32_INIT_DEFAULT,
    parameter logic [31:0] CRC_XOROUT = CRC32_XOROUT_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_sof,
    input  logic                         in_eof,
    input  logic [$clog2(DATA_W/8):0]    in_bytes,
    output logic                         crc_valid,
    input  logic                         crc_ready,
    output logic [31:0]                  crc_out
`ifdef CRC32_STREAM_CHECK_EN
    ,
    output logic                         crc_ok,
    output logic                         crc_err
`endif
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned BW = $clog2(NB) + 1;

    crc_state_t     state;
    crc_state_t     state_next;
    logic [31:0]    crc_reg;
    logic           accept;
    logic           fold_en;
    logic [BW-1:0]  nbytes;
    logic [NB-1:0]  lane_en;
    logic [31:0]    chain [0:NB];

    assign accept  = in_valid && (state != ST_HOLD);
    assign fold_en = accept && ((state == ST_ACCUM) || in_sof);

    always_comb begin
        nbytes = in_bytes;
        if ((in_bytes == '0) || (in_bytes > BW'(NB))) begin
            nbytes = BW'(NB);
        end
    end

    // Frame start (sof, or any beat taken in IDLE) seeds the chain from CRC_INIT.
    assign chain[0] = ((state == ST_IDLE) || in_sof) ? CRC_INIT : crc_reg;

    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign lane_en[i] = !in_eof || (BW'(i) < nbytes);

        crc32_byte_fold u_fold (
            .crc_in  (chain[i]),
            .data    (in_data[8*i +: 8]),
            .enable  (lane_en[i]),
            .crc_out (chain[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b1;
        crc_valid  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (in_valid && in_sof) begin
                    state_next = in_eof ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid && in_eof) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                in_ready  = 1'b0;
                crc_valid = 1'b1;
                if (crc_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_reg <= CRC_INIT;
            crc_out <= '0;
        end else if (fold_en) begin
            crc_reg <= chain[NB];
            if (in_eof) begin
                crc_out <= chain[NB] ^ CRC_XOROUT;
            end
        end
    end

`ifdef CRC32_STREAM_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_ok <= 1'b0;
        end else if (fold_en && in_eof) begin
            crc_ok <= (chain[NB] == CRC32_RESIDUE);
        end
    end

    assign crc_err = !crc_ok;
`endif

endmodule

// File: tb/tb_crc32_stream.sv
// Scoreboard bench for crc32_stream: DATA_W=8 and DATA_W=32 instances against a bitwise CRC model.
module tb_crc32_stream;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        v8 = 1'b0, sof8 = 1'b0, eof8 = 1'b0, cr8 = 1'b0;
    logic [7:0]  data8 = '0;
    logic [0:0]  bytes8 = 1'b1;
    logic        rdy8, cv8;
    logic [31:0] co8;

    logic        v32 = 1'b0, sof32 = 1'b0, eof32 = 1'b0, cr32 = 1'b0;
    logic [31:0] data32 = '0;
    logic [2:0]  bytes32 = 3'd4;
    logic        rdy32, cv32;
    logic [31:0] co32;

`ifdef CRC32_STREAM_CHECK_EN
    logic ok8, err8, ok32, err32;
`endif

    int nvec = 0;
    int nerr = 0;
    logic [31:0] exp8  [$];
    logic [31:0] exp32 [$];
    logic        expok [$];

    crc32_stream #(.DATA_W(8)) u_d8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8), .in_data(data8),
        .in_sof(sof8), .in_eof(eof8), .in_bytes(bytes8), .crc_valid(cv8),
        .crc_ready(cr8), .crc_out(co8)
`ifdef CRC32_STREAM_CHECK_EN
        , .crc_ok(ok8), .crc_err(err8)
`endif
    );

    crc32_stream #(.DATA_W(32)) u_d32 (
        .clk(clk), .reset(reset), .in_valid(v32), .in_ready(rdy32), .in_data(data32),
        .in_sof(sof32), .in_eof(eof32), .in_bytes(bytes32), .crc_valid(cv32),
        .crc_ready(cr32), .crc_out(co32)
`ifdef CRC32_STREAM_CHECK_EN
        , .crc_ok(ok32), .crc_err(err32)
`endif
    );

    // Bit-serial reference: shift each data bit through the reflected LFSR.
    function automatic logic [31:0] model_step(input logic [31:0] c, input logic [7:0] b);
        logic fb;
        for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ b[k];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    task automatic beat8(input logic [7:0] d, input logic s, input logic e);
        v8 = 1'b1; data8 = d; sof8 = s; eof8 = e; bytes8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0; sof8 = 1'b0; eof8 = 1'b0;
    endtask

    task automatic send_str8(input string s);
        for (int i = 0; i < s.len(); i++) begin
            beat8(s[i], i == 0, i == s.len() - 1);
        end
    endtask

    task automatic wait_cv8(output bit to);
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cv8) begin to = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_cv32(output bit to);
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cv32) begin to = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic ack8();
        cr8 = 1'b1; @(negedge clk); cr8 = 1'b0;
    endtask

    task automatic ack32();
        cr32 = 1'b1; @(negedge clk); cr32 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        nvec++; if (cv8 !== 1'b0)   begin nerr++; $display("FAIL reset_cv8: got %b want 0", cv8); end
        nvec++; if (rdy8 !== 1'b1)  begin nerr++; $display("FAIL reset_rdy8: got %b want 1", rdy8); end
        nvec++; if (co8 !== 32'h0)  begin nerr++; $display("FAIL reset_co8: got %h want 0", co8); end
        nvec++; if (cv32 !== 1'b0)  begin nerr++; $display("FAIL reset_cv32: got %b want 0", cv32); end
        nvec++; if (rdy32 !== 1'b1) begin nerr++; $display("FAIL reset_rdy32: got %b want 1", rdy32); end
        nvec++; if (co32 !== 32'h0) begin nerr++; $display("FAIL reset_co32: got %h want 0", co32); end
    endtask

    task automatic test_check_string8();
        bit to; logic [31:0] e;
        exp8.push_back(32'hCBF43926);
        send_str8("123456789");
        nvec++; if (cv8 !== 1'b1) begin nerr++; $display("FAIL str8_latency: crc_valid got %b want 1", cv8); end
        wait_cv8(to);
        e = exp8.pop_front();
        nvec++; if (to || co8 !== e) begin nerr++; $display("FAIL str8_crc: got %h want %h timeout=%0d", co8, e, to); end
        ack8();
    endtask

    task automatic test_check_string32();
        bit to; logic [31:0] e;
        logic [31:0] words [3];
        words[0] = 32'h34333231; words[1] = 32'h38373635; words[2] = 32'hA5A5A539;
        exp32.push_back(32'hCBF43926);
        for (int i = 0; i < 3; i++) begin
            v32 = 1'b1; data32 = words[i]; sof32 = (i == 0); eof32 = (i == 2);
            bytes32 = (i == 2) ? 3'd1 : 3'd4;
            @(negedge clk);
        end
        v32 = 1'b0; sof32 = 1'b0; eof32 = 1'b0;
        wait_cv32(to);
        e = exp32.pop_front();
        nvec++; if (to || co32 !== e) begin nerr++; $display("FAIL str32_crc: got %h want %h timeout=%0d", co32, e, to); end
        ack32();
    endtask

    task automatic test_hold();
        bit to; logic [31:0] e;
        exp8.push_back(32'hD202EF8D);
        beat8(8'h00, 1'b1, 1'b1);
        wait_cv8(to);
        e = exp8.pop_front();
        nvec++; if (to) begin nerr++; $display("FAIL hold_arrive: crc_valid never rose"); end
        // A new frame offered while holding must be refused.
        v8 = 1'b1; data8 = 8'hFF; sof8 = 1'b1; eof8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nvec++; if (cv8 !== 1'b1) begin nerr++; $display("FAIL hold_cv[%0d]: got %b want 1", i, cv8); end
            nvec++; if (co8 !== e)    begin nerr++; $display("FAIL hold_co[%0d]: got %h want %h", i, co8, e); end
            nvec++; if (rdy8 !== 1'b0) begin nerr++; $display("FAIL hold_rdy[%0d]: got %b want 0", i, rdy8); end
            @(negedge clk);
        end
        v8 = 1'b0; sof8 = 1'b0; eof8 = 1'b0;
        ack8();
        nvec++; if (cv8 !== 1'b0)  begin nerr++; $display("FAIL hold_release_cv: got %b want 0", cv8); end
        nvec++; if (rdy8 !== 1'b1) begin nerr++; $display("FAIL hold_release_rdy: got %b want 1", rdy8); end
        nvec++; if (co8 !== e)     begin nerr++; $display("FAIL hold_idle_co: got %h want %h", co8, e); end
    endtask

    task automatic test_drop_and_restart();
        bit to; logic [31:0] e;
        beat8(8'h55, 1'b0, 1'b1);
        nvec++; if (cv8 !== 1'b0) begin nerr++; $display("FAIL drop_nosof: crc_valid got %b want 0", cv8); end
        exp8.push_back(32'hCBF43926);
        beat8(8'h41, 1'b1, 1'b0);
        beat8(8'h42, 1'b0, 1'b0);
        send_str8("123456789");
        wait_cv8(to);
        e = exp8.pop_front();
        nvec++; if (to || co8 !== e) begin nerr++; $display("FAIL restart_crc: got %h want %h timeout=%0d", co8, e, to); end
        ack8();
    endtask

    task automatic test_reset_on_eof();
        string s = "12345678";
        for (int i = 0; i < s.len(); i++) beat8(s[i], i == 0, 1'b0);
        v8 = 1'b1; data8 = 8'h39; eof8 = 1'b1; cr8 = 1'b1; reset = 1'b1;
        @(negedge clk);
        v8 = 1'b0; eof8 = 1'b0; cr8 = 1'b0; reset = 1'b0;
        nvec++; if (cv8 !== 1'b0)  begin nerr++; $display("FAIL rsteof_cv: got %b want 0", cv8); end
        nvec++; if (rdy8 !== 1'b1) begin nerr++; $display("FAIL rsteof_rdy: got %b want 1", rdy8); end
        nvec++; if (co8 !== 32'h0) begin nerr++; $display("FAIL rsteof_co: got %h want 0", co8); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++; if (cv8 !== 1'b0) begin nerr++; $display("FAIL rsteof_stay[%0d]: got %b want 0", i, cv8); end
        end
    endtask

    task automatic test_random32();
        bit to; logic [31:0] e, c, w;
        logic [7:0] fb [16];
        int n, nbeats, rem;
        logic [2:0] odd [5];
        odd[0] = 3'd4; odd[1] = 3'd0; odd[2] = 3'd5; odd[3] = 3'd6; odd[4] = 3'd7;
        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 13);
            c = 32'hFFFFFFFF;
            for (int j = 0; j < n; j++) begin
                fb[j] = 8'($urandom);
                c = model_step(c, fb[j]);
            end
            exp32.push_back(c ^ 32'hFFFFFFFF);
            nbeats = (n + 3) / 4;
            for (int b = 0; b < nbeats; b++) begin
                w = $urandom;
                rem = n - 4 * b;
                for (int l = 0; l < 4; l++) if (l < rem) w[8*l +: 8] = fb[4*b + l];
                v32 = 1'b1; data32 = w; sof32 = (b == 0); eof32 = (b == nbeats - 1);
                bytes32 = 3'($urandom);
                if (b == nbeats - 1) bytes32 = (rem >= 4) ? odd[$urandom_range(0, 4)] : 3'(rem);
                @(negedge clk);
                v32 = 1'b0; sof32 = 1'b0; eof32 = 1'b0;
                if ($urandom_range(0, 2) == 0 && b != nbeats - 1) @(negedge clk);
            end
            wait_cv32(to);
            e = exp32.pop_front();
            nvec++; if (to || co32 !== e) begin nerr++; $display("FAIL rand32[%0d] n=%0d: got %h want %h timeout=%0d", f, n, co32, e, to); end
            ack32();
        end
    endtask

`ifdef CRC32_STREAM_CHECK_EN
    task automatic test_check_en();
        bit to; logic eok;
        logic [7:0] fr [13];
        string s = "123456789";
        for (int i = 0; i < 9; i++) fr[i] = s[i];
        fr[9] = 8'h26; fr[10] = 8'h39; fr[11] = 8'hF4; fr[12] = 8'hCB;
        for (int t = 0; t < 4; t++) begin
            int pos; int bitn;
            logic [7:0] m [13];
            for (int i = 0; i < 13; i++) m[i] = fr[i];
            if (t > 0) begin
                pos = $urandom_range(0, 12); bitn = $urandom_range(0, 7);
                m[pos][bitn] = ~m[pos][bitn];
            end
            expok.push_back(t == 0);
            for (int i = 0; i < 13; i++) beat8(m[i], i == 0, i == 12);
            wait_cv8(to);
            eok = expok.pop_front();
            nvec++; if (to || ok8 !== eok || err8 !== !eok)
                begin nerr++; $display("FAIL check_en[%0d]: ok=%b err=%b want ok=%b timeout=%0d", t, ok8, err8, eok, to); end
            ack8();
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_check_string8();
        test_check_string32();
        test_hold();
        test_drop_and_restart();
        test_reset_on_eof();
        test_random32();
`ifdef CRC32_STREAM_CHECK_EN
        test_check_en();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
